// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: op-codes, FSM encoding and
// default datapath sizes matching the 8x8 register bank.
package cpu_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: add, subtract, logic ops and 1-bit shifts.
// MUL is not handled here and yields a zero result.
module alu_core
   import cpu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v,
   output logic             z
);

   logic [WIDTH:0] ext;

   // NOTE: every output gets a default first so no path can leave a value
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      ext    = '0;
      case (op)
         OP_ADD: begin
            ext    = {1'b0, a} + {1'b0, b};
            result = ext[WIDTH-1:0];
            c      = ext[WIDTH];
            v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // The extra top bit of the widened difference is the borrow.
            ext    = {1'b0, a} - {1'b0, b};
            result = ext[WIDTH-1:0];
            c      = ext[WIDTH];
            v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            c      = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            c      = a[0];
         end
         default: result = '0;
      endcase
   end

   assign z = (result == '0);

endmodule

// File: rtl/alu_exec.sv
// Execute stage between the register bank read ports and its write port.
// Single-cycle ops complete in 2 cycles; MUL is a WIDTH-step shift-add.
module alu_exec
   import cpu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rd,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t               state, state_next;
   op_t                  op_in;
   logic [WIDTH-1:0]     b_reg;
   logic [2*WIDTH-1:0]   acc, mcand, acc_next;
   logic [CNT_W-1:0]     count;
   logic                 mul_last;
   logic [WIDTH-1:0]     core_result;
   logic                 core_c, core_v, core_z;

   assign op_in = op_t'(op);

   // The core sees the operands in the accept cycle, so its outputs equal
   // what is captured at that edge and can be registered straight into DONE.
   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (a),
      .b      (b),
      .op     (op_in),
      .result (core_result),
      .c      (core_c),
      .v      (core_v),
      .z      (core_z)
   );

   assign acc_next = b_reg[0] ? (acc + mcand) : acc;
   assign mul_last = (count == CNT_W'(WIDTH - 1));

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = (op_in == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:   if (mul_last) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign busy  = (state != S_IDLE);
   assign done  = (state == S_DONE);
   assign wr_en = (state == S_DONE);

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         b_reg   <= '0;
         acc     <= '0;
         mcand   <= '0;
         count   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  wr_addr <= rd;
                  if (op_in == OP_MUL) begin
                     acc   <= '0;
                     mcand <= {{WIDTH{1'b0}}, a};
                     b_reg <= b;
                     count <= '0;
                  end else begin
                     wr_data <= core_result;
                     flag_z  <= core_z;
                     flag_c  <= core_c;
                     flag_v  <= core_v;
                  end
               end
            end
            S_MUL: begin
               acc   <= acc_next;
               mcand <= mcand << 1;
               b_reg <= b_reg >> 1;
               count <= count + CNT_W'(1);
               // Final iteration: publish the sum that is landing in acc now.
               if (mul_last) begin
                  wr_data <= acc_next[WIDTH-1:0];
                  flag_z  <= (acc_next[WIDTH-1:0] == '0);
                  flag_c  <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                  flag_v  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected writes are queued at stimulus time
// and popped by a monitor whenever the DUT strobes its write port.
module tb_alu_exec;
   import cpu_pkg::*;

   localparam int W  = 8;
   localparam int AW = 3;

   typedef struct {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic          z, c, v;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [AW-1:0] rd = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, wr_en, flag_z, flag_c, flag_v;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;

   int   n_cmp = 0;
   int   n_err = 0;
   int   wr_count = 0;
   exp_t sb[$];
   exp_t mon_e;

   alu_exec #(.WIDTH(W), .ADDR_W(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rd      (rd),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .flag_v  (flag_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [AW-1:0] r);
      exp_t e;
      int   ux, uy, sx, sy, s;
      logic [15:0] p;
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
      e.addr = r;
      e.data = '0;
      e.c    = 1'b0;
      e.v    = 1'b0;
      case (o)
         OP_ADD: begin
            s = ux + uy;
            e.data = 8'(s);
            e.c = (s > 255);
            s = sx + sy;
            e.v = (s > 127) || (s < -128);
         end
         OP_SUB: begin
            e.data = 8'(ux - uy);
            e.c = (ux < uy);
            s = sx - sy;
            e.v = (s > 127) || (s < -128);
         end
         OP_AND: e.data = x & y;
         OP_OR:  e.data = x | y;
         OP_XOR: e.data = x ^ y;
         OP_SHL: begin
            e.data = 8'(ux * 2);
            e.c = x[7];
         end
         OP_SHR: begin
            e.data = 8'(ux / 2);
            e.c = x[0];
         end
         default: begin
            p = 16'(ux * uy);
            e.data = p[7:0];
            e.c = (p[15:8] != 8'h00);
         end
      endcase
      e.z = (e.data == 8'h00);
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && wr_en) begin
         wr_count++;
         check("done_with_wr", 32'(done), 32'(1));
         if (sb.size() == 0) begin
            check("unexpected_wr", 32'(sb.size()), 32'(1));
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            check("wr_data", 32'(wr_data), 32'(mon_e.data));
            check("flag_z", 32'(flag_z), 32'(mon_e.z));
            check("flag_c", 32'(flag_c), 32'(mon_e.c));
            check("flag_v", 32'(flag_v), 32'(mon_e.v));
         end
      end
   end

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [AW-1:0] rv);
      int lat;
      int exp_lat;
      exp_lat = (o == OP_MUL) ? 9 : 1;
      @(negedge clk);
      start = 1'b1;
      op = o;
      a = av;
      b = bv;
      rd = rv;
      sb.push_back(model(o, av, bv, rv));
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      rd = 3'($urandom);
      check({tag, "_busy"}, 32'(busy), 32'(1));
      lat = 1;
      while (!done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      check({tag, "_idle"}, 32'(busy), 32'(0));
      check({tag, "_done_low"}, 32'(done), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      #3;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_wr_en", 32'(wr_en), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_wr_data", 32'(wr_data), 32'(0));
      check("rst_flags", 32'({flag_z, flag_c, flag_v}), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      run_op("add_ovf", OP_ADD, 8'h7F, 8'h01, 3'd3);
      run_op("sub_borrow", OP_SUB, 8'h02, 8'h03, 3'd1);
      run_op("shl", OP_SHL, 8'h81, 8'h00, 3'd2);
      run_op("shr", OP_SHR, 8'h81, 8'h00, 3'd4);
      run_op("and", OP_AND, 8'hF0, 8'h3C, 3'd0);
      run_op("or", OP_OR, 8'h0F, 8'hF0, 3'd5);
      run_op("xor_zero", OP_XOR, 8'hAA, 8'hAA, 3'd6);
      run_op("add_carry", OP_ADD, 8'hFF, 8'h01, 3'd7);
      run_op("sub_ovf", OP_SUB, 8'h80, 8'h01, 3'd2);
      run_op("mul_0f_11", OP_MUL, 8'h0F, 8'h11, 3'd6);
      run_op("mul_10_10", OP_MUL, 8'h10, 8'h10, 3'd7);
      run_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 3'd1);

      for (int i = 0; i < 20; i++) begin
         run_op("rand", 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
      end

      // Start pulses while a MUL is in flight must be dropped, not queued.
      base = wr_count;
      @(negedge clk);
      start = 1'b1;
      op = OP_MUL;
      a = 8'h05;
      b = 8'h0B;
      rd = 3'd4;
      sb.push_back(model(OP_MUL, 8'h05, 8'h0B, 3'd4));
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start = (n == 3) || (n == 8) || (n == 9);
         op = OP_ADD;
         a = 8'h01;
         b = 8'h01;
         rd = 3'd7;
      end
      check("ignored_start_writes", 32'(wr_count - base), 32'(1));
      check("ignored_start_idle", 32'(busy), 32'(0));

      // Async reset in the middle of a MUL aborts it without a write.
      run_op("pre_rst_add", OP_ADD, 8'h7F, 8'h01, 3'd3);
      base = wr_count;
      @(negedge clk);
      start = 1'b1;
      op = OP_MUL;
      a = 8'h10;
      b = 8'h10;
      rd = 3'd2;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_busy", 32'(busy), 32'(1));
      check("pre_rst_flag_v", 32'(flag_v), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'(0));
      check("async_rst_wr_en", 32'(wr_en), 32'(0));
      check("async_rst_flags", 32'({flag_z, flag_c, flag_v}), 32'(0));
      check("async_rst_wr_data", 32'(wr_data), 32'(0));
      check("async_rst_wr_addr", 32'(wr_addr), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("aborted_mul_writes", 32'(wr_count - base), 32'(0));
      run_op("post_rst_add", OP_ADD, 8'h01, 8'h01, 3'd5);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
